// File: rtl/sram_axis_reader_pkg.sv
// Shared constants and types for the SRAM-to-AXI-Stream reader.
//   MAX_ADDR_WIDTH : SRAM word address width
//   NUM_SRAMS      : width of the bank index field
//   SRAM_WIDTH_O   : SRAM read-data width
//   FIFO_DEPTH     : return-data buffer depth
//   state_e        : reader FSM state encoding
package sram_axis_reader_pkg;

  localparam int unsigned MAX_ADDR_WIDTH = 4;
  localparam int unsigned NUM_SRAMS      = 4;
  localparam int unsigned SRAM_WIDTH_O   = 16;
  localparam int unsigned FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry show-ahead FIFO holding SRAM words that could not be forwarded
// straight to the stream. rdata always presents the oldest entry.
//   clk, rst        : clock, synchronous active-low reset
//   push, wdata     : write strobe and data (caller never pushes when full)
//   pop             : remove head entry (caller never pops when empty)
//   rdata           : head entry
//   full, empty     : occupancy flags
module sram_rd_fifo
  import sram_axis_reader_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [FIFO_DEPTH];
  logic [Width-1:0] mem_d [FIFO_DEPTH];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wptr_q] = wdata;
    end
    wptr_d  = wptr_q ^ push;
    rptr_d  = rptr_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    rdata   = mem_q[rptr_q];
    full    = (count_q == 2'(FIFO_DEPTH));
    empty   = (count_q == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sram_axis_reader.sv
// Reads cfg_len words from one SRAM bank, starting at cfg_base_addr, and
// streams the low C_AXIS_TDATA_WIDTH bits of each word as AXI-Stream beats.
// Optional feature macro: SRAM_READER_STRIDE_EN adds cfg_stride as the address
// increment; without it the increment is 1.
//   clk, rst                     : clock, synchronous active-low reset
//   start, cfg_idx, cfg_base_addr, cfg_len (, cfg_stride) : job launch/config
//   busy, done                   : job active, one-cycle completion pulse
//   sram_out_en/idx/addr, sram_out_data : SRAM read port, 1-cycle latency
//   m_axis_tdata/tvalid/tready/tlast    : AXI-Stream master
module sram_axis_reader
  import sram_axis_reader_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_SRAMS-1:0]           cfg_idx,
  input  logic [MAX_ADDR_WIDTH-1:0]      cfg_base_addr,
  input  logic [MAX_ADDR_WIDTH:0]        cfg_len,
`ifdef SRAM_READER_STRIDE_EN
  input  logic [MAX_ADDR_WIDTH-1:0]      cfg_stride,
`endif
  output logic                           busy,
  output logic                           done,
  output logic                           sram_out_en,
  output logic [NUM_SRAMS-1:0]           sram_out_idx,
  output logic [MAX_ADDR_WIDTH-1:0]      sram_out_addr,
  input  logic signed [SRAM_WIDTH_O-1:0] sram_out_data,
  output logic [C_AXIS_TDATA_WIDTH-1:0]  m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
);

  localparam logic [MAX_ADDR_WIDTH:0] LenOne = 1;

  state_e                        state_q, state_d;
  logic [NUM_SRAMS-1:0]          idx_q, idx_d;
  logic [MAX_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [MAX_ADDR_WIDTH:0]       len_q, len_d;
  logic [MAX_ADDR_WIDTH:0]       issued_q, issued_d;
  logic [MAX_ADDR_WIDTH:0]       beats_q, beats_d;
  logic                          inflight_q, inflight_d;
  logic                          done_q, done_d;
  logic [MAX_ADDR_WIDTH-1:0]     stride;

  logic [C_AXIS_TDATA_WIDTH-1:0] sram_word;
  logic [C_AXIS_TDATA_WIDTH-1:0] fifo_rdata;
  logic                          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [1:0]                    fifo_occ;
  logic                          beat_xfer;
  logic                          unused_sram_hi;

`ifdef SRAM_READER_STRIDE_EN
  logic [MAX_ADDR_WIDTH-1:0]     stride_q, stride_d;
  assign stride = stride_q;
`else
  assign stride = {{(MAX_ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

  assign sram_word      = sram_out_data[C_AXIS_TDATA_WIDTH-1:0];
  assign unused_sram_hi = ^sram_out_data[SRAM_WIDTH_O-1:C_AXIS_TDATA_WIDTH];
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign sram_out_idx   = idx_q;
  assign sram_out_addr  = addr_q;

  // Datapath: buffered words go first; otherwise the word returning from the
  // SRAM this cycle is offered directly, and only parked in the FIFO if the
  // sink does not take it.
  always_comb begin
    fifo_occ      = {fifo_full, ~fifo_full & ~fifo_empty};
    m_axis_tvalid = !fifo_empty || inflight_q;
    if (!fifo_empty) begin
      m_axis_tdata = fifo_rdata;
    end else if (inflight_q) begin
      m_axis_tdata = sram_word;
    end else begin
      m_axis_tdata = '0;
    end
    m_axis_tlast = m_axis_tvalid && (beats_q == len_q - LenOne);
    beat_xfer    = m_axis_tvalid && m_axis_tready;
    fifo_pop     = beat_xfer && !fifo_empty;
    fifo_push    = inflight_q && !(beat_xfer && fifo_empty);
    // Never have more words outstanding than the FIFO could absorb.
    sram_out_en  = (state_q == StRun) && (({1'b0, fifo_occ} + {2'b00, inflight_q}) < 3'd2);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    beats_d    = beats_q;
    inflight_d = sram_out_en;
    done_d     = 1'b0;
`ifdef SRAM_READER_STRIDE_EN
    stride_d   = stride_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_len != '0) begin
            state_d  = StRun;
            idx_d    = cfg_idx;
            addr_d   = cfg_base_addr;
            len_d    = cfg_len;
            issued_d = '0;
            beats_d  = '0;
`ifdef SRAM_READER_STRIDE_EN
            stride_d = cfg_stride;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (sram_out_en) begin
          addr_d   = addr_q + stride;
          issued_d = issued_q + LenOne;
          if (issued_q == len_q - LenOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (beat_xfer && m_axis_tlast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (beat_xfer) begin
      beats_d = beats_q + LenOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef SRAM_READER_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
`ifdef SRAM_READER_STRIDE_EN
      stride_q   <= stride_d;
`endif
    end
  end

  sram_rd_fifo #(
    .Width(C_AXIS_TDATA_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(sram_word),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_sram_axis_reader.sv
// Directed bench for sram_axis_reader with a behavioural 1-cycle SRAM and a
// scoreboard of expected beats.
module tb_sram_axis_reader;
  import sram_axis_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [3:0]  cfg_base_addr = '0;
  logic [4:0]  cfg_len = '0;
  logic [3:0]  cfg_stride = 4'd1;
  logic        busy, done, sram_out_en;
  logic [3:0]  sram_out_idx, sram_out_addr;
  logic signed [15:0] sram_rdata = '0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;

  logic [15:0] mem [16][16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_data [$];
  bit         exp_last [$];
  logic [3:0] addr_log [$];
  bit         mon_en = 1'b0;
  int         nbeats, done_cnt, first_valid_cyc, last_cyc, done_cyc;
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [3:0] cur_idx = '0;
  logic [7:0] mon_d;
  bit         mon_l;

  sram_axis_reader #(
    .C_AXIS_TDATA_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_idx      (cfg_idx),
    .cfg_base_addr(cfg_base_addr),
    .cfg_len      (cfg_len),
`ifdef SRAM_READER_STRIDE_EN
    .cfg_stride   (cfg_stride),
`endif
    .busy         (busy),
    .done         (done),
    .sram_out_en  (sram_out_en),
    .sram_out_idx (sram_out_idx),
    .sram_out_addr(sram_out_addr),
    .sram_out_data(sram_rdata),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_out_en) sram_rdata <= mem[sram_out_idx][sram_out_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_en"}, 32'(sram_out_en), 32'd0);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    check({tag, "_addr"}, 32'(sram_out_addr), 32'd0);
    check({tag, "_idx"}, 32'(sram_out_idx), 32'd0);
    check({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
  endtask

  // Stream/SRAM monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("stall_tdata", 32'(m_axis_tdata), 32'(prev_data));
        check("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_data.size() == 0) begin
          check("extra_beat", 32'(exp_data.size()), 32'd1);
        end else begin
          mon_d = exp_data.pop_front();
          mon_l = exp_last.pop_front();
          check("tdata", 32'(m_axis_tdata), 32'(mon_d));
          check("tlast", 32'(m_axis_tlast), 32'(mon_l));
        end
        nbeats++;
        if (m_axis_tlast) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", 32'(busy), 32'd0);
      end
      if (sram_out_en) begin
        addr_log.push_back(sram_out_addr);
        check("sram_idx", 32'(sram_out_idx), 32'(cur_idx));
      end
    end
  end

  task automatic run_job(input logic [3:0] idx, input logic [3:0] base, input logic [4:0] len,
                         input logic [3:0] stride, input bit toggle, input int abort_at);
    logic [3:0] a;
    logic [3:0] exp_addr [$];
    int         start_cyc;
    exp_data.delete();
    exp_last.delete();
    addr_log.delete();
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      exp_data.push_back(mem[idx][a][7:0]);
      exp_last.push_back(i == int'(len) - 1);
      exp_addr.push_back(a);
      a = a + stride;
    end
    nbeats = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    last_cyc = -1;
    done_cyc = -1;
    stall_prev = 1'b0;
    cur_idx = idx;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_idx = idx;
    cfg_base_addr = base;
    cfg_len = len;
    cfg_stride = stride;
    m_axis_tready = 1'b1;
    start_cyc = cyc;
    for (int k = 1; k < 300; k++) begin
      @(posedge clk); #1;
      start = (k == 3);  // a second launch while busy must be ignored
      if (k == 1) begin
        check("busy_after_start", 32'(busy), 32'(len != 0));
        cfg_idx = 4'd5;
        cfg_base_addr = 4'd9;
        cfg_len = 5'd2;
        cfg_stride = 4'd2;
      end
      m_axis_tready = toggle ? (k % 3 == 0) : 1'b1;
      if (done_cyc >= 0) break;
      if (abort_at != 0 && nbeats >= abort_at) break;
    end
    start = 1'b0;
    if (abort_at == 0) begin
      check("done_seen", 32'(done_cyc >= 0), 32'd1);
      @(posedge clk); #1;
      check("beats", 32'(nbeats), 32'(len));
      check("exp_left", 32'(exp_data.size()), 32'd0);
      check("done_count", 32'(done_cnt), 32'd1);
      check("n_reads", 32'(addr_log.size()), 32'(len));
      foreach (exp_addr[i]) begin
        if (i < addr_log.size()) check("read_addr", 32'(addr_log[i]), 32'(exp_addr[i]));
      end
      if (!toggle) begin
        if (len == 0) begin
          check("len0_done_time", 32'(done_cyc), 32'(start_cyc + 1));
          check("len0_no_valid", 32'(first_valid_cyc), 32'hffff_ffff);
        end else begin
          check("first_valid_time", 32'(first_valid_cyc), 32'(start_cyc + 2));
          check("last_beat_time", 32'(last_cyc), 32'(start_cyc + 1 + int'(len)));
          check("done_time", 32'(done_cyc), 32'(start_cyc + 2 + int'(len)));
        end
      end
      mon_en = 1'b0;
    end
  endtask

  initial begin
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        if (b == 2) mem[b][a] = {8'hA5, 8'(a + 1)};
        else        mem[b][a] = {8'h5A, 8'(8'hC0 + 8'(a) + 8'(b))};
      end
    end

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_job(4'd2, 4'd0, 5'd8, 4'd1, 1'b0, 0);   // full rate
    run_job(4'd2, 4'd0, 5'd8, 4'd1, 1'b1, 0);   // backpressure 1,0,0,...
    run_job(4'd2, 4'd14, 5'd4, 4'd1, 1'b0, 0);  // address wrap
    run_job(4'd3, 4'd5, 5'd0, 4'd1, 1'b0, 0);   // empty job

    // Abort after the third beat.
    run_job(4'd2, 4'd0, 5'd8, 4'd1, 1'b0, 3);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset("abort");
    rst = 1'b1;
    exp_data.delete();
    exp_last.delete();
    done_cnt = 0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    mon_en = 1'b0;
    run_job(4'd2, 4'd0, 5'd8, 4'd1, 1'b0, 0);

`ifdef SRAM_READER_STRIDE_EN
    run_job(4'd2, 4'd1, 5'd3, 4'd3, 1'b0, 0);
`else
    run_job(4'd3, 4'd1, 5'd3, 4'd1, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_axis_reader.md
SRAM_AXIS_READER -- requirements
Module: sram_axis_reader

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 8, AXI-Stream beat width; MAX_ADDR_WIDTH, NUM_SRAMS and SRAM_WIDTH_O SHALL come from params.vh.
REQ-002 SHALL have: clk  in  1  single clock for all logic.
REQ-003 SHALL have: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have: start  in  1  one-cycle job launch pulse.
REQ-005 SHALL have: cfg_idx  in  NUM_SRAMS  source bank index; cfg_base_addr  in  MAX_ADDR_WIDTH  first word; cfg_len  in  MAX_ADDR_WIDTH+1  beat count.
REQ-006 SHALL have: busy  out  1  job active; done  out  1  one-cycle completion pulse.
REQ-007 SHALL have: sram_out_en  out  1; sram_out_idx  out  NUM_SRAMS; sram_out_addr  out  MAX_ADDR_WIDTH; sram_out_data  in  SRAM_WIDTH_O (signed).
REQ-008 SHALL have: m_axis_tdata  out  C_AXIS_TDATA_WIDTH; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1.

Function
REQ-009 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with cfg_len!=0, RUN->DRAIN after the last read issues, DRAIN->IDLE on the handshake of the tlast beat.
REQ-010 SHALL latch cfg_* on start in IDLE; start while busy SHALL be ignored, and cfg_* changes while busy SHALL have no effect.
REQ-011 start with cfg_len==0 SHALL keep the state in IDLE, issue no reads, and pulse done the next cycle.
REQ-012 SHALL treat the SRAM read latency as exactly 1 cycle: sram_out_data is valid the cycle after sram_out_en=1.
REQ-013 SHALL issue a read only when (FIFO occupancy + reads in flight) < 2, so no returned word is ever dropped.
REQ-014 read addresses SHALL be base, base+stride, ... modulo 2^MAX_ADDR_WIDTH (wrap-around, no error).
REQ-015 m_axis_tdata SHALL be sram_out_data[C_AXIS_TDATA_WIDTH-1:0] of the corresponding word, in issue order.
REQ-016 tvalid/tdata/tlast SHALL stay stable while tvalid=1 and tready=0; a beat transfers only when tvalid and tready are both 1.
REQ-017 with tready held at 1, the block SHALL sustain 1 beat/cycle; first tvalid SHALL assert 2 cycles after start.
REQ-018 tlast SHALL be 1 only on beat cfg_len-1; done SHALL pulse the cycle after the tlast handshake, and busy SHALL fall in the same cycle.
REQ-019 sram_out_idx SHALL equal the latched cfg_idx whenever sram_out_en=1; sram_out_en SHALL be 0 outside RUN.

Reset
REQ-020 rst=0 at a clock edge SHALL force IDLE, empty the FIFO, clear in-flight tracking, and drive busy, done, sram_out_en, m_axis_tvalid and m_axis_tlast to 0, with sram_out_addr, sram_out_idx and m_axis_tdata at 0.
REQ-021 reset mid-job SHALL abort the job without a done pulse; the first start after reset SHALL behave as if from power-up.

Configuration
REQ-022 macro SRAM_READER_STRIDE_EN defined: SHALL add input cfg_stride (MAX_ADDR_WIDTH), latched on start, as the address increment; undefined: no port, and the stride SHALL be fixed at 1.

Structure
REQ-023 state encodings and the FIFO depth constant (2) SHALL live in params.vh, alongside MAX_ADDR_WIDTH/NUM_SRAMS/SRAM_WIDTH_O.
REQ-024 the return-data buffer SHALL be a separate sub-module sram_rd_fifo (2-entry, show-ahead, full/empty flags).

Verification
REQ-025 bench SHALL cover: preload bank 2 addr 0..7 = 1..8; start idx=2, base=0, len=8, tready=1 -> beats 1..8 on consecutive cycles, tlast on the 8th beat, done 1 cycle later.
REQ-026 bench SHALL cover: same job with tready toggling 1,0,0,1,... -> beats 1..8 in order, none lost or duplicated, tdata stable during stalls.
REQ-027 bench SHALL cover: base=2^MAX_ADDR_WIDTH-2, len=4 -> addresses max-1, max, 0, 1 in that order.
REQ-028 bench SHALL cover: len=0 -> no sram_out_en, no tvalid, done pulse 1 cycle after start.
REQ-029 bench SHALL cover: rst=0 after the 3rd beat of an 8-beat job -> outputs at reset values next cycle, no done; a new job then returns correct data.
REQ-030 bench SHALL cover: SRAM_READER_STRIDE_EN defined, stride=3, base=1, len=3 -> reads of addresses 1, 4, 7.
